seq_add_ctrl: RTL and testbench
===============================

SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 Parameter NWORDS, default 4, number of 16-bit slices; operand width W = 16*NWORDS; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a new addition; sampled only in IDLE or DONE.
REQ-005 a  input  W  operand A; sampled on accepted start.
REQ-006 b  input  W  operand B; sampled on accepted start.
REQ-007 cin  input  1  carry-in; sampled on accepted start.
REQ-008 busy  output  1  high while slices are being computed.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 s  output  W  registered sum; stable from done until the next accepted start.
REQ-011 cout  output  1  registered final carry-out; same validity as s.

Function
REQ-012 The block SHALL contain exactly one 16-bit carry-lookahead adder slice, reused once per cycle for NWORDS cycles.
REQ-013 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-014 IDLE: start=1 latches a, b and cin into internal registers, clears slice counter to 0, clears s, and moves to RUN; start=0 stays in IDLE.
REQ-015 RUN: each cycle, slice k = counter computes a[16k+15:16k] + b[16k+15:16k] + carry_reg; result goes to s[16k+15:16k]; slice carry-out goes to carry_reg; counter increments.
REQ-016 carry_reg SHALL equal latched cin for slice 0.
REQ-017 RUN with counter = NWORDS-1 SHALL load cout from the slice carry-out and move to DONE.
REQ-018 DONE: done=1 for exactly this one cycle; start=1 behaves as in IDLE (back-to-back accepted); start=0 moves to IDLE.
REQ-019 Latency: start accepted at edge 0 -> busy high for NWORDS cycles -> done high in cycle NWORDS+1 (5 for NWORDS=4).
REQ-020 start in RUN SHALL be ignored; latched operands are unaffected by input changes after acceptance.
REQ-021 busy=1 exactly in RUN; busy and done are never high together.
REQ-022 Arithmetic is modulo 2^W; {cout,s} SHALL equal a+b+cin.
REQ-023 s and cout SHALL hold their value in IDLE after DONE until the next accepted start.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, counter=0, carry_reg=0, s=0, cout=0, busy=0, done=0; this has priority over start.
REQ-025 rst during RUN SHALL abort the operation with no done pulse; the partial sum is discarded.

Configuration
REQ-026 Macro SEQ_ADD_CTRL_OVF_EN: when defined, output ovf (1 bit, registered) SHALL be added; it is set with cout to the signed overflow of the full-width add (a[W-1]==b[W-1] and s[W-1]!=a[W-1]), reset 0, same validity as s.
REQ-027 Without SEQ_ADD_CTRL_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (NWORDS=4)
REQ-028 Reset, then a=0, b=0, cin=0, start one cycle -> busy cycles 1-4, done in cycle 5, s=0, cout=0.
REQ-029 a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> s=0x0000_0000_0001_0000, cout=0 (inter-slice carry).
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0, cout=1; with OVF_EN ovf=0.
REQ-031 a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> s=0x8000_0000_0000_0000, cout=0; with OVF_EN ovf=1.
REQ-032 start held high during RUN with different operands -> ignored, first result correct; start in DONE cycle with a=3, b=4 -> second done exactly 5 cycles later, s=7.
REQ-033 rst asserted in the 2nd RUN cycle -> next cycle busy=0, s=0, cout=0, no done pulse; a following start completes normally.

Source files
------------

// File: rtl/seq_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_add_ctrl
// Purpose  : Multi-cycle W-bit adder (W = 16*NWORDS). A single 16-bit
//            carry-lookahead slice is reused once per cycle, least
//            significant slice first, with the carry kept in a register
//            between cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NWORDS   number of 16-bit slices (2..8), default 4
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   i_start  in   1  request a new addition (honoured in IDLE/DONE only)
//   i_a      in   W  operand A, captured on accepted start
//   i_b      in   W  operand B, captured on accepted start
//   i_cin    in   1  carry-in, captured on accepted start
//   o_busy   out  1  high while slices are being computed
//   o_done   out  1  one-cycle pulse, result valid
//   o_s      out  W  registered sum, held until the next accepted start
//   o_cout   out  1  registered final carry-out
//   o_ovf    out  1  registered signed overflow (SEQ_ADD_CTRL_OVF_EN only)
// Build option
//   SEQ_ADD_CTRL_OVF_EN  adds the o_ovf output and its register
// ============================================================================
module seq_add_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [16*NWORDS-1:0] i_a,
  input  logic [16*NWORDS-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [16*NWORDS-1:0] o_s,
  output logic                 o_cout
`ifdef SEQ_ADD_CTRL_OVF_EN
  ,
  output logic                 o_ovf
`endif
);

  localparam int              c_W    = 16 * NWORDS;
  localparam int              c_CW   = $clog2(NWORDS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [c_W-1:0]   r_a;
  logic [c_W-1:0]   r_b;
  logic [c_W-1:0]   r_s;
  logic             r_carry;
  logic             r_cout;
  logic [c_CW-1:0]  r_cnt;
`ifdef SEQ_ADD_CTRL_OVF_EN
  logic             r_ovf;
`endif

  // Slice operands and carry-lookahead internals
  logic [15:0]      w_op_a;
  logic [15:0]      w_op_b;
  logic [15:0]      w_g;
  logic [15:0]      w_p;
  logic [15:0]      w_c;
  logic [3:0]       w_grp_g;
  logic [3:0]       w_grp_p;
  logic [4:0]       w_grp_c;
  logic [15:0]      w_sum;
  logic             w_co;
  logic             w_last;

  assign w_op_a = r_a[r_cnt*16 +: 16];
  assign w_op_b = r_b[r_cnt*16 +: 16];
  assign w_g    = w_op_a & w_op_b;
  assign w_p    = w_op_a ^ w_op_b;
  assign w_last = (r_cnt == c_LAST);

  // Two-level lookahead: four 4-bit groups each produce group generate and
  // propagate, group carries are resolved from those, and bit carries inside
  // each group are expanded directly from the group carry-in.
  always_comb begin
    w_grp_g = '0;
    w_grp_p = '0;
    w_grp_c = '0;
    w_c     = '0;
    w_grp_c[0] = r_carry;
    for (int j = 0; j < 4; j++) begin
      w_grp_g[j] = w_g[4*j+3]
                 | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      w_grp_p[j] = &w_p[4*j +: 4];
      w_grp_c[j+1] = w_grp_g[j] | (w_grp_p[j] & w_grp_c[j]);
      w_c[4*j]   = w_grp_c[j];
      w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_grp_c[j]);
      w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+1] & w_p[4*j] & w_grp_c[j]);
      w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_grp_c[j]);
    end
  end

  assign w_sum = w_p ^ w_c;
  assign w_co  = w_grp_c[4];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = i_start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture on accepted start, one slice per RUN cycle.
  // cout is deliberately left alone on start; it is only rewritten by the
  // last slice, so it keeps the previous result until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SEQ_ADD_CTRL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_s     <= '0;
          end
        end
        S_RUN: begin
          r_s[r_cnt*16 +: 16] <= w_sum;
          r_carry             <= w_co;
          if (w_last) begin
            r_cout <= w_co;
            r_cnt  <= '0;
`ifdef SEQ_ADD_CTRL_OVF_EN
            // The top slice's MSB is the full-width sign bit of the sum
            r_ovf  <= (r_a[c_W-1] == r_b[c_W-1]) && (w_sum[15] != r_a[c_W-1]);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_s    = r_s;
  assign o_cout = r_cout;
`ifdef SEQ_ADD_CTRL_OVF_EN
  assign o_ovf  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_add_ctrl
// Purpose  : Self-checking bench for seq_add_ctrl (NWORDS = 4). Expected
//            results are modelled when an operation is launched, queued, and
//            popped when the DUT pulses done.
// Revision : 1.0 - initial release
// Build option
//   SEQ_ADD_CTRL_OVF_EN  also checks the o_ovf output
// ============================================================================
module tb_seq_add_ctrl;

  localparam int NWORDS = 4;
  localparam int W      = 16 * NWORDS;
  localparam int BOUND  = 4 * NWORDS + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s;
  logic         busy;
  logic         done;
  logic         cout;
`ifdef SEQ_ADD_CTRL_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W:0] sum;   // {cout, s}
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  seq_add_ctrl #(.NWORDS(NWORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_s     (s),
    .o_cout  (cout)
`ifdef SEQ_ADD_CTRL_OVF_EN
    ,
    .o_ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    e.sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
`ifdef SEQ_ADD_CTRL_OVF_EN
    e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Snapshot of the DUT result outputs in scoreboard layout
  function automatic exp_t observed();
    exp_t r;
    r.sum = {cout, s};
`ifdef SEQ_ADD_CTRL_OVF_EN
    r.ovf = ovf;
`else
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  // Drive one accepted start; returns in cycle 1 of the operation
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(x, y, c));
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; cyc is the cycle index where done was seen
  task automatic await_done(output int cyc, output int nbusy, output bit overlap,
                            output bit ok);
    cyc = 1; nbusy = 0; overlap = 1'b0; ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    rst = 1'b1;
    tick();
    start = 1'b1;   // reset must win over start
    tick();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++;
    if (s !== '0) begin miscompares++; $display("FAIL reset_s: got %h expected 0", s); end
    vectors++;
    if (cout !== 1'b0) begin miscompares++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef SEQ_ADD_CTRL_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    start = 1'b0;
    rst   = 1'b0;
    tick();
  endtask

  task automatic test_add();
    logic [W-1:0] ta[8];
    logic [W-1:0] tb[8];
    logic         tc[8];
    int cyc, nbusy; bit overlap, ok;
    exp_t e, o;
    ta[0] = 64'h0;                   tb[0] = 64'h0; tc[0] = 1'b0;
    ta[1] = 64'h0000_0000_0000_FFFF; tb[1] = 64'h1; tc[1] = 1'b0;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb[2] = 64'h0; tc[2] = 1'b1;
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb[3] = 64'h1; tc[3] = 1'b0;
    ta[4] = 64'h8000_0000_0000_0000; tb[4] = 64'h8000_0000_0000_0000; tc[4] = 1'b1;
    for (int i = 5; i < 8; i++) begin
      ta[i] = {$urandom, $urandom};
      tb[i] = {$urandom, $urandom};
      tc[i] = 1'($urandom_range(1, 0));
    end
    for (int i = 0; i < 8; i++) begin
      launch(ta[i], tb[i], tc[i]);
      await_done(cyc, nbusy, overlap, ok);
      vectors++;
      if (!ok || cyc != NWORDS + 1 || nbusy != NWORDS || overlap) begin
        miscompares++;
        $display("FAIL add%0d_timing: got done_cycle=%0d busy_cycles=%0d overlap=%0b seen=%0b expected %0d/%0d/0/1",
                 i, cyc, nbusy, overlap, ok, NWORDS + 1, NWORDS);
      end
      e = sb.pop_front();
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL add%0d_result: got cout,s=%h ovf=%b expected %h ovf=%b",
                 i, o.sum, o.ovf, e.sum, e.ovf);
      end
      // Back in IDLE: result must hold, no second done
      for (int k = 0; k < 2; k++) begin
        tick();
        o = observed();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || o !== e) begin
          miscompares++;
          $display("FAIL add%0d_hold%0d: got done=%b busy=%b cout,s=%h expected 0/0/%h",
                   i, k, done, busy, o.sum, e.sum);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nbusy; bit overlap, ok;
    exp_t e, o;
    launch(64'h1111_2222_3333_4444, 64'h0FFF_F000_FFFF_FFFF, 1'b1);
    ok = 1'b0; cyc = 1;
    // Hold start with changing operands throughout RUN; it must be ignored
    for (int i = 0; i < BOUND; i++) begin
      if (done) begin ok = 1'b1; break; end
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'b0;
      start = 1'b1;
      tick();
      cyc++;
    end
    vectors++;
    if (!ok || cyc != NWORDS + 1) begin
      miscompares++;
      $display("FAIL b2b_first_timing: got done_cycle=%0d seen=%0b expected %0d/1", cyc, ok, NWORDS + 1);
    end
    e = sb.pop_front();
    o = observed();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL b2b_first_result: got %h expected %h", o.sum, e.sum);
    end
    // Start in the DONE cycle is accepted
    launch(64'd3, 64'd4, 1'b0);
    await_done(cyc, nbusy, overlap, ok);
    vectors++;
    if (!ok || cyc != NWORDS + 1 || overlap) begin
      miscompares++;
      $display("FAIL b2b_second_timing: got done_cycle=%0d seen=%0b overlap=%0b expected %0d/1/0",
               cyc, ok, overlap, NWORDS + 1);
    end
    e = sb.pop_front();
    o = observed();
    vectors++;
    if (o !== e || s !== 64'd7) begin
      miscompares++;
      $display("FAIL b2b_second_result: got s=%h cout=%b expected s=%h cout=%b", s, cout, e.sum[W-1:0], e.sum[W]);
    end
    tick();
  endtask

  task automatic test_reset_in_run();
    int cyc, nbusy; bit overlap, ok, seen_done;
    exp_t e, o;
    // Leave cout=1 so that the abort clearing it is observable
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    await_done(cyc, nbusy, overlap, ok);
    e = sb.pop_front();
    o = observed();
    vectors++;
    if (!ok || o !== e) begin
      miscompares++;
      $display("FAIL abort_pre_result: got seen=%0b %h expected 1/%h", ok, o.sum, e.sum);
    end
    launch(64'h5, 64'h2, 1'b0);
    void'(sb.pop_back());   // this operation is aborted, no result expected
    tick();                 // second RUN cycle
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || s !== '0 || cout !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b done=%b s=%h cout=%b expected 0/0/0/0", busy, done, s, cout);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 2 * NWORDS; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    vectors++;
    if (seen_done) begin miscompares++; $display("FAIL abort_no_done: got done pulse expected none"); end
    launch(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    await_done(cyc, nbusy, overlap, ok);
    e = sb.pop_front();
    o = observed();
    vectors++;
    if (!ok || cyc != NWORDS + 1 || o !== e) begin
      miscompares++;
      $display("FAIL abort_post_result: got seen=%0b cycle=%0d %h expected 1/%0d/%h",
               ok, cyc, o.sum, NWORDS + 1, e.sum);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_in_run();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
